dmem_load_store_unit: RTL and testbench

//  RV32I load/store unit between execute and data memory; producer of regfile load writebacks.

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_align.sv | 58 +++++
 rtl/dmem_load_store_unit.sv | 169 ++++++++++++++++
 tb/tb_dmem_load_store_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 encodings,
// FSM state type and the request legality check used at accept time.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_WB       = 2'd3
  } lsu_state_t;

  // True when the request must be rejected without touching the bus:
  // unknown funct3, unsigned/illegal widths on stores, or a misaligned address.
  function automatic logic req_rejected(input logic       is_store,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    logic bad_f3;
    logic bad_align;
    bad_f3 = 1'b0;
    unique case (funct3)
      F3_B, F3_H, F3_W: bad_f3 = 1'b0;
      F3_BU, F3_HU:     bad_f3 = is_store;
      default:          bad_f3 = 1'b1;
    endcase
    bad_align = 1'b0;
    if (funct3[1:0] == 2'b01 && addr_lo[0])
      bad_align = 1'b1;
    if (funct3 == F3_W && addr_lo != 2'b00)
      bad_align = 1'b1;
    return bad_f3 | bad_align;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data steering: store lane replication / byte enables, and
// load byte/half extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_result
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store side: replicate the operand across lanes and enable the addressed bytes.
  always_comb begin
    st_wdata = st_data;
    st_be    = 4'b0000;
    unique case (st_funct3[1:0])
      2'b00: begin
        st_wdata = {4{st_data[7:0]}};
        st_be    = 4'b0001 << st_addr_lo;
      end
      2'b01: begin
        st_wdata = {2{st_data[15:0]}};
        st_be    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        st_wdata = st_data;
        st_be    = 4'b1111;
      end
      default: begin
        st_wdata = st_data;
        st_be    = 4'b0000;
      end
    endcase
  end

  // Load side: pick the addressed lane, then extend according to funct3.
  always_comb begin
    ld_byte   = ld_rdata[{ld_addr_lo, 3'b000} +: 8];
    ld_half   = ld_rdata[{ld_addr_lo[1], 4'b0000} +: 16];
    ld_result = ld_rdata;
    unique case (ld_funct3)
      F3_B:    ld_result = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_result = {{16{ld_half[15]}}, ld_half};
      F3_BU:   ld_result = {24'h000000, ld_byte};
      F3_HU:   ld_result = {16'h0000, ld_half};
      default: ld_result = ld_rdata;
    endcase
  end

endmodule

// File: rtl/dmem_load_store_unit.sv
// Blocking, single-outstanding RV32I load/store unit between execute and data memory.
//
//   state       | meaning
//   ------------+------------------------------------------------------------
//   ST_IDLE     | ready for a request; rejected requests pulse misalign_err here
//   ST_ISSUE    | bus request held valid and stable until mem_req_ready
//   ST_WAIT_RSP | load issued; waiting for mem_rsp_valid, timeout counter runs
//   ST_WB       | one-cycle writeback slot (wb_valid high unless rd == x0)
module dmem_load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign_err,
  output logic        bus_err
);

  // Last WAIT_RSP count before giving up; reaching it completes TIMEOUT_CYCLES waits.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state, state_nxt;
  logic [7:0]  to_cnt, to_cnt_nxt;
  logic        capture;
  logic        wb_load;
  logic        wb_valid_nxt;
  logic        misalign_nxt;
  logic        bus_err_nxt;

  logic [2:0]  cap_funct3;
  logic [1:0]  cap_addr_lo;
  logic [4:0]  cap_rd;

  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [31:0] ld_result;

  assign req_ready     = (state == ST_IDLE);
  assign mem_req_valid = (state == ST_ISSUE);

  lsu_align u_align (
    .st_funct3  (req_funct3),
    .st_addr_lo (req_addr[1:0]),
    .st_data    (req_wdata),
    .st_wdata   (st_wdata),
    .st_be      (st_be),
    .ld_funct3  (cap_funct3),
    .ld_addr_lo (cap_addr_lo),
    .ld_rdata   (mem_rdata),
    .ld_result  (ld_result)
  );

  // State, timeout counter and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      to_cnt       <= 8'd0;
      wb_valid     <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      state        <= state_nxt;
      to_cnt       <= to_cnt_nxt;
      wb_valid     <= wb_valid_nxt;
      misalign_err <= misalign_nxt;
      bus_err      <= bus_err_nxt;
    end
  end

  // Next-state decode; pulses are computed here and registered above.
  always_comb begin
    state_nxt    = state;
    to_cnt_nxt   = to_cnt;
    capture      = 1'b0;
    wb_load      = 1'b0;
    wb_valid_nxt = 1'b0;
    misalign_nxt = 1'b0;
    bus_err_nxt  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (req_valid) begin
          capture = 1'b1;
          if (req_rejected(req_is_store, req_funct3, req_addr[1:0]))
            misalign_nxt = 1'b1;
          else
            state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem_req_ready) begin
          if (mem_we) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt  = ST_WAIT_RSP;
            to_cnt_nxt = 8'd0;
          end
        end
      end
      ST_WAIT_RSP: begin
        if (mem_rsp_valid) begin
          state_nxt    = ST_WB;
          wb_load      = (cap_rd != 5'd0);
          wb_valid_nxt = (cap_rd != 5'd0);
        end else if (to_cnt == TO_LAST) begin
          state_nxt   = ST_IDLE;
          to_cnt_nxt  = 8'd0;
          bus_err_nxt = 1'b1;
        end else begin
          to_cnt_nxt = to_cnt + 8'd1;
        end
      end
      ST_WB: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Request capture, bus-side registers and writeback data (held when idle).
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_funct3  <= 3'd0;
      cap_addr_lo <= 2'd0;
      cap_rd      <= 5'd0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'd0;
      mem_wdata   <= 32'd0;
      mem_be      <= 4'd0;
      wb_rd       <= 5'd0;
      wb_data     <= 32'd0;
    end else begin
      if (capture) begin
        cap_funct3  <= req_funct3;
        cap_addr_lo <= req_addr[1:0];
        cap_rd      <= req_rd;
        mem_we      <= req_is_store;
        mem_addr    <= {req_addr[31:2], 2'b00};
        mem_wdata   <= st_wdata;
        mem_be      <= st_be;
      end
      if (wb_load) begin
        wb_rd   <= cap_rd;
        wb_data <= ld_result;
      end
    end
  end

endmodule

// File: tb/tb_dmem_load_store_unit.sv
// Directed bench for dmem_load_store_unit: table of single transactions plus
// hand-written stall, timeout and reset-abandon sequences.
module tb_dmem_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign_err;
  logic        bus_err;

  int n_cmp;
  int n_bad;

  dmem_load_store_unit #(.TIMEOUT_CYCLES(255)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_is_store  (req_is_store),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_rd        (req_rd),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .misalign_err  (misalign_err),
    .bus_err       (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        exp_err;
    logic [31:0] exp_maddr;
    logic [3:0]  exp_be;
    logic [31:0] exp_mwdata;
    logic        exp_wbv;
    logic [31:0] exp_wbd;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [4:0] rd);
    @(negedge clk);
    req_valid    = 1'b1;
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = a;
    req_wdata    = wd;
    req_rd       = rd;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string p;
    p = $sformatf("v%0d", idx);
    drive_req(v.is_store, v.f3, v.addr, v.wdata, v.rd);
    chk({p, "_req_ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    if (v.exp_err) begin
      chk({p, "_misalign"}, 32'(misalign_err), 32'd1);
      chk({p, "_no_bus"}, 32'(mem_req_valid), 32'd0);
      chk({p, "_ready_back"}, 32'(req_ready), 32'd1);
      @(negedge clk);
      chk({p, "_misalign_drop"}, 32'(misalign_err), 32'd0);
      chk({p, "_still_no_bus"}, 32'(mem_req_valid), 32'd0);
    end else begin
      chk({p, "_mem_req_valid"}, 32'(mem_req_valid), 32'd1);
      chk({p, "_mem_we"}, 32'(mem_we), 32'(v.is_store));
      chk({p, "_mem_addr"}, mem_addr, v.exp_maddr);
      if (v.is_store) begin
        chk({p, "_mem_be"}, 32'(mem_be), 32'(v.exp_be));
        chk({p, "_mem_wdata"}, mem_wdata, v.exp_mwdata);
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      chk({p, "_mem_req_drop"}, 32'(mem_req_valid), 32'd0);
      if (v.is_store) begin
        chk({p, "_st_ready"}, 32'(req_ready), 32'd1);
        chk({p, "_st_no_wb"}, 32'(wb_valid), 32'd0);
      end else begin
        chk({p, "_ld_busy"}, 32'(req_ready), 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rdata     = v.rdata;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk({p, "_wb_valid"}, 32'(wb_valid), 32'(v.exp_wbv));
        chk({p, "_wb_data"}, wb_data, v.exp_wbd);
        if (v.exp_wbv)
          chk({p, "_wb_rd"}, 32'(wb_rd), 32'(v.rd));
        @(negedge clk);
        chk({p, "_wb_pulse"}, 32'(wb_valid), 32'd0);
        chk({p, "_ld_ready"}, 32'(req_ready), 32'd1);
      end
    end
  endtask

  initial begin
    int  n;
    bit  got;
    bit  flag;

    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 32'd0;

    //          st  f3      addr          wdata         rd     rdata         err  maddr         be       mwdata        wbv  wbd
    vecs[0]  = '{1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 5'd0,  32'h0,        1'b0, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 5'd0,  32'h0,        1'b0, 32'h0000_0100, 4'b1000, 32'hA5A5_A5A5, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 5'd0,  32'h0,        1'b0, 32'h0000_0100, 4'b1100, 32'hABCD_ABCD, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 3'b000, 32'h0000_0102, 32'h0,         5'd5,  32'h1280_5634, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        1'b1, 32'hFFFF_FF80};
    vecs[4]  = '{1'b0, 3'b100, 32'h0000_0102, 32'h0,         5'd6,  32'h1280_5634, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        1'b1, 32'h0000_0080};
    vecs[5]  = '{1'b0, 3'b001, 32'h0000_0102, 32'h0,         5'd7,  32'h8000_1234, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        1'b1, 32'hFFFF_8000};
    vecs[6]  = '{1'b0, 3'b101, 32'h0000_0100, 32'h0,         5'd8,  32'h1234_F00D, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        1'b1, 32'h0000_F00D};
    vecs[7]  = '{1'b0, 3'b010, 32'h0000_0104, 32'h0,         5'd9,  32'hCAFE_BABE, 1'b0, 32'h0000_0104, 4'b0000, 32'h0,        1'b1, 32'hCAFE_BABE};
    vecs[8]  = '{1'b0, 3'b000, 32'h0000_0101, 32'h0,         5'd10, 32'h1280_5634, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        1'b1, 32'h0000_0056};
    vecs[9]  = '{1'b0, 3'b001, 32'h0000_0101, 32'h0,         5'd11, 32'h0,        1'b1, 32'h0,         4'b0000, 32'h0,        1'b0, 32'h0};
    vecs[10] = '{1'b0, 3'b010, 32'h0000_0102, 32'h0,         5'd11, 32'h0,        1'b1, 32'h0,         4'b0000, 32'h0,        1'b0, 32'h0};
    vecs[11] = '{1'b0, 3'b011, 32'h0000_0100, 32'h0,         5'd11, 32'h0,        1'b1, 32'h0,         4'b0000, 32'h0,        1'b0, 32'h0};
    vecs[12] = '{1'b1, 3'b100, 32'h0000_0100, 32'h55,        5'd0,  32'h0,        1'b1, 32'h0,         4'b0000, 32'h0,        1'b0, 32'h0};
    vecs[13] = '{1'b1, 3'b010, 32'h0000_0201, 32'h77,        5'd0,  32'h0,        1'b1, 32'h0,         4'b0000, 32'h0,        1'b0, 32'h0};
    vecs[14] = '{1'b0, 3'b010, 32'h0000_0108, 32'h0,         5'd0,  32'h1111_1111, 1'b0, 32'h0000_0108, 4'b0000, 32'h0,        1'b0, 32'h0000_0056};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_errs", 32'({misalign_err, bus_err}), 32'd0);

    for (int i = 0; i < 15; i++)
      run_vec(vecs[i], i);

    // Bus back-pressure: request must stay valid and stable, new requests refused.
    drive_req(1'b0, 3'b010, 32'h0000_010C, 32'h0, 5'd3);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h0000_0FF0;
    flag = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (mem_req_valid !== 1'b1 || mem_addr !== 32'h0000_010C || mem_we !== 1'b0 || req_ready !== 1'b0)
        flag = 1'b0;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("stall_stable", 32'(flag), 32'd1);
    chk("stall_addr", mem_addr, 32'h0000_010C);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h0BAD_F00D;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("stall_wb_valid", 32'(wb_valid), 32'd1);
    chk("stall_wb_rd", 32'(wb_rd), 32'd3);
    chk("stall_wb_data", wb_data, 32'h0BAD_F00D);
    @(negedge clk);

    // Response timeout.
    drive_req(1'b0, 3'b010, 32'h0000_0110, 32'h0, 5'd4);
    @(negedge clk);
    req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    n = 0; got = 1'b0; flag = 1'b0;
    while (n < 400 && !got) begin
      @(negedge clk);
      n++;
      if (wb_valid) flag = 1'b1;
      if (bus_err) got = 1'b1;
    end
    chk("timeout_seen", 32'(got), 32'd1);
    chk("timeout_cycles", 32'(n), 32'd255);
    chk("timeout_no_wb", 32'(flag), 32'd0);
    chk("timeout_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("timeout_pulse", 32'(bus_err), 32'd0);
    chk("timeout_wb_data_held", wb_data, 32'h0BAD_F00D);

    // Reset while waiting for a response; a late response must be ignored.
    drive_req(1'b0, 3'b010, 32'h0000_0120, 32'h0, 5'd12);
    @(negedge clk);
    req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid_ready", 32'(req_ready), 32'd1);
    chk("rstmid_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rstmid_wb_data", wb_data, 32'd0);
    chk("rstmid_wb_rd", 32'(wb_rd), 32'd0);
    chk("rstmid_mem_addr", mem_addr, 32'd0);
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h7777_7777;
    flag = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (wb_valid || bus_err || misalign_err) flag = 1'b1;
    end
    mem_rsp_valid = 1'b0;
    chk("rstmid_late_rsp_ignored", 32'(flag), 32'd0);
    chk("rstmid_wb_data_kept", wb_data, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so a stuck handshake cannot hang the run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
